// File: rtl/uart_rx_buffer_ctrl.sv
// uart_rx_buffer_ctrl
//   Receive-side buffer behind the UART-lite character recovery block.
//   - Queues char/valid strobes in a first-word-fall-through FIFO.
//   - Presents the FIFO head to the host on a valid/ready handshake.
//   - Raises a sticky overrun flag when a character arrives while the FIFO is full.
//   - Optional line-idle timeout, enabled by defining UART_RX_IDLE_TIMEOUT_EN:
//     pulses idle_o once the line has stayed idle for IDLE_CHARS character
//     times after the last accepted character.
module uart_rx_buffer_ctrl #(
  parameter int DATA_BITS     = 8,
  parameter int DEPTH         = 4,
  parameter int OVERSAMPLING  = 16,
  parameter int IDLE_POLARITY = 1,
  parameter int IDLE_CHARS    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic [DATA_BITS-1:0]       char_i,
  input  logic                       char_valid_i,
  input  logic                       rx_i,
  output logic [DATA_BITS-1:0]       data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overrun_o,
  output logic                       idle_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 overrun_q;

  logic full;
  logic pop;
  logic push;
  logic drop;

  // Handshake decode: a full FIFO still accepts a character when the head
  // leaves in the same cycle, so the newcomer lands at the tail.
  assign full = (count_q == FULL_CNT);
  assign pop  = valid_o & ready_i;
  assign push = char_valid_i & enable_i & (~full | pop);
  assign drop = char_valid_i & enable_i & full & ~pop;

  assign data_o    = mem[rd_ptr_q];
  assign valid_o   = (count_q != '0);
  assign count_o   = count_q;
  assign overrun_o = overrun_q;

  // Storage write; contents are not reset, a flush only moves the pointers.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      mem[wr_ptr_q] <= char_i;
    end
  end

  // Pointers, occupancy and sticky overrun; clear wins over push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else if (clear_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

`ifdef UART_RX_IDLE_TIMEOUT_EN

  localparam int TIMEOUT = IDLE_CHARS * (DATA_BITS + 2) * OVERSAMPLING;
  localparam int TMR_W   = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic             IDLE_LVL = 1'(IDLE_POLARITY);

  typedef enum logic {DISARMED = 1'b0, ARMED = 1'b1} idle_state_e;

  idle_state_e      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             idle_q, idle_d;

  // Idle FSM state register; the pulse is registered so idle_o is glitch-free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DISARMED;
      tmr_q   <= '0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idle_q  <= idle_d;
    end
  end

  // Idle FSM next state: the pulse fires on the edge the timer reaches
  // TIMEOUT, i.e. TIMEOUT edges after the last push or line activity.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idle_d  = 1'b0;
    if (clear_i) begin
      state_d = DISARMED;
      tmr_d   = '0;
    end else begin
      case (state_q)
        DISARMED: begin
          if (push) begin
            state_d = ARMED;
            tmr_d   = '0;
          end
        end
        ARMED: begin
          if (push || (rx_i != IDLE_LVL)) begin
            tmr_d = '0;
          end else if (tmr_q == TMR_LAST) begin
            idle_d  = 1'b1;
            state_d = DISARMED;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        default: begin
          state_d = DISARMED;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // Idle FSM output.
  always_comb begin
    idle_o = idle_q;
  end

`else

  // Without the idle timer the line input and its timing parameters have no role.
  localparam int unused_idle_cfg = IDLE_CHARS + IDLE_POLARITY + OVERSAMPLING;
  logic unused_rx;
  assign unused_rx = rx_i;

  // Idle output tied off.
  always_comb begin
    idle_o = 1'b0;
  end

`endif

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Directed bench for uart_rx_buffer_ctrl: a vector table for the FIFO,
// handshake, overrun and clear behaviour, plus hand-written reset and
// idle-timeout sequences. Works with UART_RX_IDLE_TIMEOUT_EN defined or not.
module tb_uart_rx_buffer_ctrl;

  localparam int DATA_BITS = 8;
  localparam int DEPTH     = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 enable_i;
  logic                 clear_i;
  logic [DATA_BITS-1:0] char_i;
  logic                 char_valid_i;
  logic                 rx_i;
  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [2:0]           count_o;
  logic                 overrun_o;
  logic                 idle_o;

  uart_rx_buffer_ctrl #(
    .DATA_BITS(DATA_BITS), .DEPTH(DEPTH), .OVERSAMPLING(16),
    .IDLE_POLARITY(1), .IDLE_CHARS(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .clear_i(clear_i),
    .char_i(char_i), .char_valid_i(char_valid_i), .rx_i(rx_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .count_o(count_o), .overrun_o(overrun_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Inputs applied before an edge, outputs expected just after it.
  typedef struct {
    logic       en;
    logic       clr;
    logic       vld;
    logic [7:0] chr;
    logic       rdy;
    logic [2:0] e_cnt;
    logic       e_vld;
    logic [7:0] e_dat;
    logic       e_ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic clr, input logic vld, input logic [7:0] chr,
                     input logic rdy, input logic [2:0] e_cnt, input logic e_vld,
                     input logic [7:0] e_dat, input logic e_ovr);
    vec_t v;
    v.en = en; v.clr = clr; v.vld = vld; v.chr = chr; v.rdy = rdy;
    v.e_cnt = e_cnt; v.e_vld = e_vld; v.e_dat = e_dat; v.e_ovr = e_ovr;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    enable_i = 1'b1; clear_i = 1'b0; char_valid_i = 1'b0; char_i = '0; ready_i = 1'b0;
  endtask

  int first_pulse;
  int n_pulses;
  int exp_first;
  int exp_pulses;

  initial begin
    rst_ni = 1'b0; rx_i = 1'b1;
    idle_inputs();

    // ---- reset state ----
    #12;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ovr",   32'(overrun_o), 32'd0);
    check("rst_idle",  32'(idle_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    step();

    // ---- async reset mid-burst with two characters queued ----
    char_valid_i = 1'b1; char_i = 8'hE1; step();
    char_i = 8'hE2; step();
    check("burst_count", 32'(count_o), 32'd2);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_count", 32'(count_o), 32'd0);
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_ovr",   32'(overrun_o), 32'd0);
    check("arst_idle",  32'(idle_o), 32'd0);
    char_valid_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    step();

    // ---- vector table ----
    //  en clr vld chr   rdy  cnt vld dat   ovr
    add(1, 0, 1, 8'hA5, 0,   1, 1, 8'hA5, 0);
    add(1, 0, 1, 8'h3C, 0,   2, 1, 8'hA5, 0);
    add(1, 0, 0, 8'h00, 1,   1, 1, 8'h3C, 0);
    add(1, 0, 0, 8'h00, 1,   0, 0, 8'h00, 0);
    add(1, 0, 1, 8'h01, 0,   1, 1, 8'h01, 0);
    add(1, 0, 1, 8'h02, 0,   2, 1, 8'h01, 0);
    add(1, 0, 1, 8'h03, 0,   3, 1, 8'h01, 0);
    add(1, 0, 1, 8'h04, 0,   4, 1, 8'h01, 0);
    add(1, 0, 1, 8'h05, 0,   4, 1, 8'h01, 1);
    add(1, 1, 0, 8'h00, 0,   0, 0, 8'h00, 0);
    add(1, 0, 1, 8'h01, 0,   1, 1, 8'h01, 0);
    add(1, 0, 1, 8'h02, 0,   2, 1, 8'h01, 0);
    add(1, 0, 1, 8'h03, 0,   3, 1, 8'h01, 0);
    add(1, 0, 1, 8'h04, 0,   4, 1, 8'h01, 0);
    add(1, 0, 1, 8'h55, 1,   4, 1, 8'h02, 0);
    add(1, 0, 0, 8'h00, 1,   3, 1, 8'h03, 0);
    add(1, 0, 0, 8'h00, 1,   2, 1, 8'h04, 0);
    add(1, 0, 0, 8'h00, 1,   1, 1, 8'h55, 0);
    add(1, 0, 0, 8'h00, 1,   0, 0, 8'h00, 0);
    add(0, 0, 1, 8'h77, 0,   0, 0, 8'h00, 0);
    add(1, 1, 1, 8'h66, 0,   0, 0, 8'h00, 0);
    add(1, 0, 1, 8'h11, 0,   1, 1, 8'h11, 0);
    add(1, 1, 1, 8'h22, 1,   0, 0, 8'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      enable_i = vecs[i].en; clear_i = vecs[i].clr; char_valid_i = vecs[i].vld;
      char_i = vecs[i].chr; ready_i = vecs[i].rdy;
      step();
      check($sformatf("v%0d_count", i), 32'(count_o), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d_valid", i), 32'(valid_o), 32'(vecs[i].e_vld));
      if (vecs[i].e_vld) check($sformatf("v%0d_data", i), 32'(data_o), 32'(vecs[i].e_dat));
      check($sformatf("v%0d_ovr", i), 32'(overrun_o), 32'(vecs[i].e_ovr));
      check($sformatf("v%0d_idle", i), 32'(idle_o), 32'd0);
    end
    idle_inputs();

    // ---- idle timeout: push, then quiet line ----
`ifdef UART_RX_IDLE_TIMEOUT_EN
    exp_first = 640; exp_pulses = 1;
`else
    exp_first = -1;  exp_pulses = 0;
`endif
    char_valid_i = 1'b1; char_i = 8'h10; step();
    char_valid_i = 1'b0;
    check("idle1_data", 32'(data_o), 32'h10);
    first_pulse = -1; n_pulses = 0;
    for (int k = 1; k <= 800; k++) begin
      step();
      if (idle_o) begin
        n_pulses++;
        if (first_pulse < 0) first_pulse = k;
      end
    end
    check("idle1_cycle",  32'(first_pulse), 32'(exp_first));
    check("idle1_pulses", 32'(n_pulses), 32'(exp_pulses));

    // drain the character; popping must not rearm the timer
    ready_i = 1'b1; step(); ready_i = 1'b0;
    check("idle_drain_count", 32'(count_o), 32'd0);

    // ---- idle timeout restarted by line activity at +300 ----
`ifdef UART_RX_IDLE_TIMEOUT_EN
    exp_first = 940;
`endif
    char_valid_i = 1'b1; char_i = 8'h20; step();
    char_valid_i = 1'b0;
    first_pulse = -1; n_pulses = 0;
    for (int k = 1; k <= 1100; k++) begin
      rx_i = (k == 300) ? 1'b0 : 1'b1;
      step();
      if (idle_o) begin
        n_pulses++;
        if (first_pulse < 0) first_pulse = k;
      end
    end
    rx_i = 1'b1;
    check("idle2_cycle",  32'(first_pulse), 32'(exp_first));
    check("idle2_pulses", 32'(n_pulses), 32'(exp_pulses));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
